// File: rtl/spi_seq_pkg.sv
// Shared state encoding, field slices and counter widths for the SPI frame sequencer.
// StDrain exists only when FRAME_TIMEOUT_EN is defined.
package spi_seq_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
`ifdef FRAME_TIMEOUT_EN
        StIssue = 2'd2,
        StDrain = 2'd3
`else
        StIssue = 2'd2
`endif
    } state_e;

    localparam int unsigned FRAME_BITS_DEFAULT = 32;
    localparam int unsigned ERR_CNT_W_DEFAULT  = 8;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned ADDR_MSB  = 23;
    localparam int unsigned WDATA_MSB = 15;
    localparam int unsigned OP_W      = 8;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned WDATA_W   = 16;

    localparam int unsigned BIT_CNT_W = 6;

endpackage

// File: rtl/spi_seq_err_counter.sv
// Saturating rejected-frame counter with a registered one-cycle error pulse.
module spi_seq_err_counter
    import spi_seq_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = ERR_CNT_W_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 inc,
    output logic                 pulse,
    output logic [ERR_CNT_W-1:0] count
);

    logic [ERR_CNT_W-1:0] count_q;
    logic                 pulse_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            // The pulse still fires once the count is pinned at all-ones.
            pulse_q <= inc;
            if (inc && (count_q != '1)) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign pulse = pulse_q;
    assign count = count_q;

endmodule

// File: rtl/spi_frame_sequencer.sv
// Frame-level controller behind the SPI slave shift register: counts, validates, decodes and
// issues commands. Define FRAME_TIMEOUT_EN to add the inter-bit idle timeout and DRAIN state.
module spi_frame_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned     FRAME_BITS     = FRAME_BITS_DEFAULT,
    parameter logic [OP_W-1:0] MAX_OP         = 8'h0F,
    parameter int unsigned     ERR_CNT_W      = ERR_CNT_W_DEFAULT,
    parameter int unsigned     TIMEOUT_CYCLES = 4096
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sclk_rise,
    input  logic                 frame_active,
    input  logic [31:0]          shift_data,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [OP_W-1:0]      cmd_op,
    output logic [ADDR_W-1:0]    cmd_addr,
    output logic [WDATA_W-1:0]   cmd_wdata,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    if (FRAME_BITS != 32) begin : g_bad_frame_bits
        $error("spi_frame_sequencer: FRAME_BITS must be 32");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("spi_frame_sequencer: TIMEOUT_CYCLES must be nonzero");
    end

    state_e               state_q;
    logic                 frame_active_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic                 cmd_valid_q;
    logic [OP_W-1:0]      cmd_op_q;
    logic [ADDR_W-1:0]    cmd_addr_q;
    logic [WDATA_W-1:0]   cmd_wdata_q;

    logic frame_start, frame_end, frame_ok, handshake, timeout, err_inc;

    assign frame_start = frame_active & ~frame_active_q;
    assign frame_end   = ~frame_active & frame_active_q;
    assign handshake   = cmd_valid_q & cmd_ready;
    assign frame_ok    = (bit_cnt_q == BIT_CNT_W'(FRAME_BITS)) &&
                         (shift_data[OP_MSB -: OP_W] <= MAX_OP);

    // frame_active_q resets high so a frame already running at reset release never starts.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_active_q <= 1'b1;
            bit_cnt_q      <= '0;
        end else begin
            frame_active_q <= frame_active;
            if (frame_start) begin
                bit_cnt_q <= sclk_rise ? BIT_CNT_W'(1) : '0;
            end else if (frame_active && sclk_rise && (bit_cnt_q != '1)) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

`ifdef FRAME_TIMEOUT_EN
    localparam int unsigned IDLE_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_CNT_W-1:0] idle_cnt_q;

    always_ff @(posedge clock) begin
        if (reset || (state_q != StShift) || sclk_rise) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle in SHIFT.
    assign timeout = (state_q == StShift) && frame_active && !sclk_rise &&
                     (idle_cnt_q == IDLE_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        err_inc = 1'b0;
        case (state_q)
            StShift: err_inc = (frame_end && !frame_ok) || timeout;
            StIssue: err_inc = frame_end;
            default: err_inc = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= '0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (frame_start) state_q <= StShift;
                end
                StShift: begin
                    if (frame_end) begin
                        if (frame_ok) begin
                            cmd_op_q    <= shift_data[OP_MSB -: OP_W];
                            cmd_addr_q  <= shift_data[ADDR_MSB -: ADDR_W];
                            cmd_wdata_q <= shift_data[WDATA_MSB -: WDATA_W];
                            cmd_valid_q <= 1'b1;
                            state_q     <= StIssue;
                        end else begin
                            state_q <= StIdle;
                        end
`ifdef FRAME_TIMEOUT_EN
                    end else if (timeout) begin
                        state_q <= StDrain;
`endif
                    end
                end
                StIssue: begin
                    // A frame that began during ISSUE keeps counting and is picked up here.
                    if (handshake) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= frame_active ? StShift : StIdle;
                    end
                end
`ifdef FRAME_TIMEOUT_EN
                StDrain: begin
                    if (frame_end) state_q <= StIdle;
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    spi_seq_err_counter #(
        .ERR_CNT_W(ERR_CNT_W)
    ) u_err_counter (
        .clock(clock),
        .reset(reset),
        .inc  (err_inc),
        .pulse(frame_err),
        .count(err_count)
    );

    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_op_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_wdata = cmd_wdata_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed, table-driven bench for spi_frame_sequencer; models the SPI shift register as stimulus.
`timescale 1ns/1ps
module tb_spi_frame_sequencer;

    localparam int unsigned TIMEOUT = 4096;

    logic        clock = 1'b0;
    logic        reset, sclk_rise, frame_active, cmd_ready, mosi;
    logic [31:0] shift_data = '0;
    logic        cmd_valid, frame_err, busy;
    logic [7:0]  cmd_op, cmd_addr, err_count;
    logic [15:0] cmd_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_err  = 0;

    typedef struct {
        logic [63:0] word;
        int          nbits;
        logic        ok;
        logic [7:0]  op;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } vec_t;

    vec_t vecs[7];

    always #5 clock = ~clock;

    // Shift register in front of the DUT: a sampled bit is visible from the next cycle.
    always @(posedge clock) if (sclk_rise) shift_data <= {shift_data[30:0], mosi};

    spi_frame_sequencer #(
        .FRAME_BITS    (32),
        .MAX_OP        (8'h0F),
        .ERR_CNT_W     (8),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sclk_rise   (sclk_rise),
        .frame_active(frame_active),
        .shift_data  (shift_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .frame_err   (frame_err),
        .err_count   (err_count),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame();
        frame_active = 1'b1;
        sclk_rise    = 1'b0;
        tick();
    endtask

    task automatic send_bits(input logic [63:0] word, input int nbits, input int first,
                             input int last);
        for (int i = first; i < last; i++) begin
            sclk_rise = 1'b1;
            mosi      = word[nbits-1-i];
            tick();
            sclk_rise = 1'b0;
            tick();
        end
    endtask

    task automatic end_frame();
        frame_active = 1'b0;
        sclk_rise    = 1'b0;
        tick();
    endtask

    task automatic send_frame(input logic [63:0] word, input int nbits);
        start_frame();
        send_bits(word, nbits, 0, nbits);
        end_frame();
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int saw_err;

        vecs[0] = '{64'h0312ABCD,   32, 1'b1, 8'h03, 8'h12, 16'hABCD};
        vecs[1] = '{64'h0312ABCD,   31, 1'b0, 8'h00, 8'h00, 16'h0000};
        vecs[2] = '{64'hA50312ABCD, 40, 1'b0, 8'h00, 8'h00, 16'h0000};
        vecs[3] = '{64'h20000000,   32, 1'b0, 8'h00, 8'h00, 16'h0000};
        vecs[4] = '{64'h0F00FFFF,   32, 1'b1, 8'h0F, 8'h00, 16'hFFFF};
        vecs[5] = '{64'h10000001,   32, 1'b0, 8'h00, 8'h00, 16'h0000};
        vecs[6] = '{64'h00000000,   32, 1'b1, 8'h00, 8'h00, 16'h0000};

        reset        = 1'b1;
        sclk_rise    = 1'b0;
        frame_active = 1'b0;
        cmd_ready    = 1'b1;
        mosi         = 1'b0;
        repeat (3) tick();
        check("reset_cmd_valid", 32'(cmd_valid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_err_count", 32'(err_count), 32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_cmd_op",    32'(cmd_op),    32'd0);
        check("reset_cmd_wdata", 32'(cmd_wdata), 32'd0);
        reset = 1'b0;
        tick();

        // Table: each frame issued with cmd_ready high.
        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].word, vecs[v].nbits);
            if (!vecs[v].ok) exp_err++;
            check("vec_cmd_valid", 32'(cmd_valid), 32'(vecs[v].ok));
            check("vec_frame_err", 32'(frame_err), 32'(!vecs[v].ok));
            check("vec_err_count", 32'(err_count), 32'(exp_err));
            if (vecs[v].ok) begin
                check("vec_cmd_op",    32'(cmd_op),    32'(vecs[v].op));
                check("vec_cmd_addr",  32'(cmd_addr),  32'(vecs[v].addr));
                check("vec_cmd_wdata", 32'(cmd_wdata), 32'(vecs[v].wdata));
            end
            tick();
            check("vec_valid_drop", 32'(cmd_valid), 32'd0);
            check("vec_err_drop",   32'(frame_err), 32'd0);
            check("vec_idle",       32'(busy),      32'd0);
        end

        // Back-pressure: first command held while an overrun frame is rejected.
        cmd_ready = 1'b0;
        send_frame(64'h05121234, 32);
        check("hold_valid", 32'(cmd_valid), 32'd1);
        repeat (3) tick();
        check("hold_valid_wait", 32'(cmd_valid), 32'd1);
        send_frame(64'h07AA5555, 32);
        exp_err++;
        check("overrun_err",       32'(frame_err), 32'd1);
        check("overrun_err_count", 32'(err_count), 32'(exp_err));
        check("overrun_valid",     32'(cmd_valid), 32'd1);
        check("overrun_op",        32'(cmd_op),    32'h05);
        check("overrun_addr",      32'(cmd_addr),  32'h12);
        check("overrun_wdata",     32'(cmd_wdata), 32'h1234);
        cmd_ready = 1'b1;
        tick();
        check("overrun_accept", 32'(cmd_valid), 32'd0);
        check("overrun_idle",   32'(busy),      32'd0);

        // Handshake during the next frame moves straight to SHIFT and that frame still decodes.
        cmd_ready = 1'b0;
        send_frame(64'h01010001, 32);
        check("pre_mid_valid", 32'(cmd_valid), 32'd1);
        start_frame();
        send_bits(64'h02345678, 32, 0, 10);
        cmd_ready = 1'b1;
        tick();
        check("mid_accept_valid", 32'(cmd_valid), 32'd0);
        check("mid_accept_busy",  32'(busy),      32'd1);
        cmd_ready = 1'b0;
        send_bits(64'h02345678, 32, 10, 32);
        end_frame();
        check("mid_valid", 32'(cmd_valid), 32'd1);
        check("mid_op",    32'(cmd_op),    32'h02);
        check("mid_addr",  32'(cmd_addr),  32'h34);
        check("mid_wdata", 32'(cmd_wdata), 32'h5678);

        // Handshake and an error-producing end in the same cycle.
        start_frame();
        send_bits(64'h03000000, 32, 0, 5);
        frame_active = 1'b0;
        cmd_ready    = 1'b1;
        tick();
        exp_err++;
        check("both_valid",     32'(cmd_valid), 32'd0);
        check("both_err",       32'(frame_err), 32'd1);
        check("both_err_count", 32'(err_count), 32'(exp_err));
        check("both_idle",      32'(busy),      32'd0);

        // Reset mid-frame, released while still selected: the remainder is ignored.
        start_frame();
        send_bits(64'h0312ABCD, 32, 0, 10);
        reset = 1'b1;
        tick();
        tick();
        reset   = 1'b0;
        exp_err = 0;
        check("midrst_err_count", 32'(err_count), 32'd0);
        saw_err = 0;
        for (int i = 10; i < 32; i++) begin
            send_bits(64'h0312ABCD, 32, i, i + 1);
            if (frame_err || cmd_valid) saw_err++;
        end
        end_frame();
        check("midrst_no_err",   32'(frame_err), 32'd0);
        check("midrst_no_cmd",   32'(cmd_valid), 32'd0);
        check("midrst_idle",     32'(busy),      32'd0);
        check("midrst_quiet",    32'(saw_err),   32'd0);
        tick();
        check("midrst_no_err_2", 32'(frame_err), 32'd0);
        send_frame(64'h0312ABCD, 32);
        check("post_rst_valid",     32'(cmd_valid), 32'd1);
        check("post_rst_op",        32'(cmd_op),    32'h03);
        check("post_rst_addr",      32'(cmd_addr),  32'h12);
        check("post_rst_wdata",     32'(cmd_wdata), 32'hABCD);
        check("post_rst_err_count", 32'(err_count), 32'd0);
        tick();

        // Stalled frame.
`ifdef FRAME_TIMEOUT_EN
        start_frame();
        send_bits(64'h0312ABCD, 32, 0, 5);
        waited = 0;
        while (!frame_err && (waited < int'(TIMEOUT) + 20)) begin
            tick();
            waited++;
        end
        exp_err++;
        check("timeout_err",       32'(frame_err), 32'd1);
        check("timeout_latency",   32'(waited),    32'(TIMEOUT - 1));
        check("timeout_err_count", 32'(err_count), 32'(exp_err));
        check("timeout_busy",      32'(busy),      32'd1);
        send_bits(64'h0312ABCD, 32, 5, 8);
        check("drain_no_err", 32'(frame_err), 32'd0);
        check("drain_busy",   32'(busy),      32'd1);
        end_frame();
        check("drain_end_err",   32'(frame_err), 32'd0);
        check("drain_end_idle",  32'(busy),      32'd0);
        tick();
        check("drain_err_count", 32'(err_count), 32'(exp_err));
        check("drain_no_cmd",    32'(cmd_valid), 32'd0);
`else
        start_frame();
        send_bits(64'h0312ABCD, 32, 0, 5);
        saw_err = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (frame_err) saw_err++;
        end
        check("stall_no_err",    32'(saw_err),   32'd0);
        check("stall_busy",      32'(busy),      32'd1);
        check("stall_err_count", 32'(err_count), 32'(exp_err));
        end_frame();
        exp_err++;
        check("stall_end_err",   32'(frame_err), 32'd1);
        check("stall_end_count", 32'(err_count), 32'(exp_err));
        tick();
`endif

        // Saturation: empty frames push the count to all-ones; the pulse keeps firing.
        for (int i = 0; i < 260; i++) send_frame(64'h0, 0);
        check("sat_err_count", 32'(err_count), 32'hFF);
        check("sat_pulse",     32'(frame_err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
